pe_ldst_port: RTL and testbench

PE_LDST_PORT -- requirements
Module: pe_ldst_port

---
 rtl/pe_ldst_port_if.sv | 48 ++++
 rtl/pe_ldst_port.sv | 149 ++++++++++++++
 tb/tb_pe_ldst_port.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_ldst_port_if.sv
// PE load/store port bus: PE request/response side plus interconnect side.
interface pe_ldst_port_if #(
  parameter int unsigned N_GLOBAL_MEM_BANKS         = 16,
  parameter int unsigned GLOBAL_MEM_PER_BANK_ADDR_L = 10,
  parameter int unsigned DATA_L                     = 32
);
  localparam int unsigned BANK_ID_L = $clog2(N_GLOBAL_MEM_BANKS);

  // PE request
  logic                                  pe_req_vld;
  logic                                  pe_req_rdy;
  logic                                  pe_req_st;
  logic [BANK_ID_L-1:0]                  pe_req_bank_id;
  logic [GLOBAL_MEM_PER_BANK_ADDR_L-1:0] pe_req_bank_addr;
  logic [DATA_L-1:0]                     pe_req_wr_data;
  // interconnect request
  logic                                  req_vld;
  logic                                  req_st;
  logic [BANK_ID_L-1:0]                  mem_bank_id;
  logic [GLOBAL_MEM_PER_BANK_ADDR_L-1:0] bank_addr;
  logic [DATA_L-1:0]                     st_data;
  logic                                  gnt;
  // interconnect return
  logic [DATA_L-1:0]                     ld_data;
  logic                                  ld_data_vld;
  // PE response and status
  logic                                  pe_rsp_vld;
  logic [DATA_L-1:0]                     pe_rsp_data;
  logic                                  pe_rsp_rdy;
  logic                                  busy;
  logic                                  proto_err;

  // Port block view
  modport slave (
    input  pe_req_vld, pe_req_st, pe_req_bank_id, pe_req_bank_addr, pe_req_wr_data,
    input  gnt, ld_data, ld_data_vld, pe_rsp_rdy,
    output pe_req_rdy, req_vld, req_st, mem_bank_id, bank_addr, st_data,
    output pe_rsp_vld, pe_rsp_data, busy, proto_err
  );

  // Environment (PE + interconnect) view
  modport master (
    output pe_req_vld, pe_req_st, pe_req_bank_id, pe_req_bank_addr, pe_req_wr_data,
    output gnt, ld_data, ld_data_vld, pe_rsp_rdy,
    input  pe_req_rdy, req_vld, req_st, mem_bank_id, bank_addr, st_data,
    input  pe_rsp_vld, pe_rsp_data, busy, proto_err
  );
endinterface

// File: rtl/pe_ldst_port.sv
// PE load/store port: request FIFO toward the memory interconnect, load
// credit tracking so returned data always has room, and an in-order
// response FIFO back to the PE.
module pe_ldst_port #(
  parameter int unsigned N_GLOBAL_MEM_BANKS         = 16,
  parameter int unsigned GLOBAL_MEM_PER_BANK_ADDR_L = 10,
  parameter int unsigned DATA_L                     = 32,
  parameter int unsigned RD_LATENCY                 = 2,
  parameter int unsigned REQ_Q_DEPTH                = 4,
  parameter int unsigned RSP_Q_DEPTH                = 4
) (
  input logic          clk,
  input logic          rst,
  pe_ldst_port_if.slave bus
);
  localparam int unsigned BANK_ID_L = $clog2(N_GLOBAL_MEM_BANKS);
  localparam int unsigned ADDR_L    = GLOBAL_MEM_PER_BANK_ADDR_L;
  localparam int unsigned RQ_PTR_L  = $clog2(REQ_Q_DEPTH);
  localparam int unsigned RQ_CNT_L  = RQ_PTR_L + 1;
  localparam int unsigned RS_PTR_L  = $clog2(RSP_Q_DEPTH);
  localparam int unsigned RS_CNT_L  = RS_PTR_L + 1;
  localparam int unsigned RS_SUM_L  = RS_CNT_L + 1;

  localparam logic [RQ_CNT_L-1:0] RQ_FULL = RQ_CNT_L'(REQ_Q_DEPTH);
  localparam logic [RS_SUM_L-1:0] RS_CAP  = RS_SUM_L'(RSP_Q_DEPTH);

  // The read latency is absorbed by the credit scheme; it is only sanity-checked.
  if (RD_LATENCY < 1 || REQ_Q_DEPTH < 2 || RSP_Q_DEPTH < 2 ||
      (REQ_Q_DEPTH & (REQ_Q_DEPTH - 1)) != 0 ||
      (RSP_Q_DEPTH & (RSP_Q_DEPTH - 1)) != 0) begin : g_bad_param
    $error("pe_ldst_port: illegal parameter combination");
  end

  typedef struct packed {
    logic                 st;
    logic [BANK_ID_L-1:0] bank_id;
    logic [ADDR_L-1:0]    addr;
    logic [DATA_L-1:0]    data;
  } req_t;

  req_t                rq_mem_q [REQ_Q_DEPTH];
  req_t                rq_mem_d [REQ_Q_DEPTH];
  logic [RQ_PTR_L-1:0] rq_wr_q, rq_wr_d, rq_rd_q, rq_rd_d;
  logic [RQ_CNT_L-1:0] rq_cnt_q, rq_cnt_d;

  logic [DATA_L-1:0]   rs_mem_q [RSP_Q_DEPTH];
  logic [DATA_L-1:0]   rs_mem_d [RSP_Q_DEPTH];
  logic [RS_PTR_L-1:0] rs_wr_q, rs_wr_d, rs_rd_q, rs_rd_d;
  logic [RS_CNT_L-1:0] rs_cnt_q, rs_cnt_d;

  logic [RS_CNT_L-1:0] inflight_q, inflight_d;
  logic                proto_err_q, proto_err_d;

  req_t                head;
  logic [RS_SUM_L-1:0] credit_sum;
  logic                credit_ok;
  logic                pe_req_rdy_int, req_vld_int, pe_rsp_vld_int;
  logic                rq_push, rq_pop, rs_push, rs_pop, ld_grant;

  // Handshake decode; status outputs are forced low while reset is asserted.
  always_comb begin
    head           = rq_mem_q[rq_rd_q];
    credit_sum     = {1'b0, inflight_q} + {1'b0, rs_cnt_q};
    credit_ok      = credit_sum < RS_CAP;
    pe_req_rdy_int = rst && (rq_cnt_q < RQ_FULL);
    req_vld_int    = rst && (rq_cnt_q != '0) && (head.st || credit_ok);
    pe_rsp_vld_int = rst && (rs_cnt_q != '0);
    rq_push        = bus.pe_req_vld && pe_req_rdy_int;
    rq_pop         = req_vld_int && bus.gnt;
    ld_grant       = rq_pop && !head.st;
    rs_push        = bus.ld_data_vld && (inflight_q != '0);
    rs_pop         = pe_rsp_vld_int && bus.pe_rsp_rdy;

    bus.pe_req_rdy  = pe_req_rdy_int;
    bus.req_vld     = req_vld_int;
    bus.req_st      = head.st;
    bus.mem_bank_id = head.bank_id;
    bus.bank_addr   = head.addr;
    bus.st_data     = head.data;
    bus.pe_rsp_vld  = pe_rsp_vld_int;
    bus.pe_rsp_data = rs_mem_q[rs_rd_q];
    bus.busy        = rst && ((rq_cnt_q != '0) || (rs_cnt_q != '0) || (inflight_q != '0));
    bus.proto_err   = rst && proto_err_q;
  end

  // Next-state for both FIFOs, the in-flight load count and the error flag.
  always_comb begin
    rq_mem_d = rq_mem_q;
    rq_wr_d  = rq_wr_q;
    rq_rd_d  = rq_rd_q;
    rq_cnt_d = rq_cnt_q;
    if (rq_push) begin
      rq_mem_d[rq_wr_q] = {bus.pe_req_st, bus.pe_req_bank_id,
                           bus.pe_req_bank_addr, bus.pe_req_wr_data};
      rq_wr_d = rq_wr_q + RQ_PTR_L'(1);
    end
    if (rq_pop) rq_rd_d = rq_rd_q + RQ_PTR_L'(1);
    if (rq_push && !rq_pop)      rq_cnt_d = rq_cnt_q + RQ_CNT_L'(1);
    else if (!rq_push && rq_pop) rq_cnt_d = rq_cnt_q - RQ_CNT_L'(1);

    rs_mem_d = rs_mem_q;
    rs_wr_d  = rs_wr_q;
    rs_rd_d  = rs_rd_q;
    rs_cnt_d = rs_cnt_q;
    if (rs_push) begin
      rs_mem_d[rs_wr_q] = bus.ld_data;
      rs_wr_d = rs_wr_q + RS_PTR_L'(1);
    end
    if (rs_pop) rs_rd_d = rs_rd_q + RS_PTR_L'(1);
    if (rs_push && !rs_pop)      rs_cnt_d = rs_cnt_q + RS_CNT_L'(1);
    else if (!rs_push && rs_pop) rs_cnt_d = rs_cnt_q - RS_CNT_L'(1);

    inflight_d = inflight_q;
    if (ld_grant && !rs_push)      inflight_d = inflight_q + RS_CNT_L'(1);
    else if (!ld_grant && rs_push) inflight_d = inflight_q - RS_CNT_L'(1);

    proto_err_d = proto_err_q || (bus.gnt && !req_vld_int) ||
                  (bus.ld_data_vld && (inflight_q == '0));
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rq_wr_q     <= '0;
      rq_rd_q     <= '0;
      rq_cnt_q    <= '0;
      rs_wr_q     <= '0;
      rs_rd_q     <= '0;
      rs_cnt_q    <= '0;
      inflight_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      rq_wr_q     <= rq_wr_d;
      rq_rd_q     <= rq_rd_d;
      rq_cnt_q    <= rq_cnt_d;
      rs_wr_q     <= rs_wr_d;
      rs_rd_q     <= rs_rd_d;
      rs_cnt_q    <= rs_cnt_d;
      inflight_q  <= inflight_d;
      proto_err_q <= proto_err_d;
    end
  end

  // FIFO storage; contents are qualified by the counters so need no reset.
  always_ff @(posedge clk) begin
    rq_mem_q <= rq_mem_d;
    rs_mem_q <= rs_mem_d;
  end
endmodule

// File: tb/tb_pe_ldst_port.sv
// Directed bench for pe_ldst_port: table of single transactions plus
// hand-written multi-cycle sequences.
module tb_pe_ldst_port;
  localparam int unsigned NB = 16;
  localparam int unsigned AL = 10;
  localparam int unsigned DL = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pe_ldst_port_if #(.N_GLOBAL_MEM_BANKS(NB), .GLOBAL_MEM_PER_BANK_ADDR_L(AL),
                    .DATA_L(DL)) bus ();

  pe_ldst_port #(
    .N_GLOBAL_MEM_BANKS(NB), .GLOBAL_MEM_PER_BANK_ADDR_L(AL), .DATA_L(DL),
    .RD_LATENCY(2), .REQ_Q_DEPTH(4), .RSP_Q_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        st;
    logic [3:0]  bank;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exp_st;
    logic [3:0]  exp_bank;
    logic [9:0]  exp_addr;
    logic [31:0] exp_st_data;
    logic [31:0] exp_rsp;
  } vec_t;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pe_req_vld       = 1'b0;
    bus.pe_req_st        = 1'b0;
    bus.pe_req_bank_id   = '0;
    bus.pe_req_bank_addr = '0;
    bus.pe_req_wr_data   = '0;
    bus.gnt              = 1'b0;
    bus.ld_data          = '0;
    bus.ld_data_vld      = 1'b0;
    bus.pe_rsp_rdy       = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    tick();
    rst = 1'b1;
  endtask

  task automatic push_req(input logic st, input logic [3:0] bank,
                          input logic [9:0] addr, input logic [31:0] data);
    bus.pe_req_vld       = 1'b1;
    bus.pe_req_st        = st;
    bus.pe_req_bank_id   = bank;
    bus.pe_req_bank_addr = addr;
    bus.pe_req_wr_data   = data;
    tick();
    bus.pe_req_vld = 1'b0;
  endtask

  // One request end to end: push, check head, grant, return data two cycles later.
  task automatic run_vec(input vec_t v);
    bus.pe_req_vld       = 1'b1;
    bus.pe_req_st        = v.st;
    bus.pe_req_bank_id   = v.bank;
    bus.pe_req_bank_addr = v.addr;
    bus.pe_req_wr_data   = v.wdata;
    #1;
    check("vec_req_rdy", bus.pe_req_rdy, 1'b1);
    tick();
    bus.pe_req_vld = 1'b0;
    #1;
    check("vec_req_vld", bus.req_vld, 1'b1);
    check("vec_req_st", bus.req_st, v.exp_st);
    check("vec_bank", bus.mem_bank_id, v.exp_bank);
    check("vec_addr", bus.bank_addr, v.exp_addr);
    if (v.exp_st) check("vec_st_data", bus.st_data, v.exp_st_data);
    bus.gnt = 1'b1;
    tick();
    bus.gnt = 1'b0;
    #1;
    check("vec_req_vld_after_pop", bus.req_vld, 1'b0);
    if (!v.exp_st) begin
      check("vec_busy_inflight", bus.busy, 1'b1);
      tick();
      bus.ld_data_vld = 1'b1;
      bus.ld_data     = v.rdata;
      #1;
      check("vec_no_bypass", bus.pe_rsp_vld, 1'b0);
      tick();
      bus.ld_data_vld = 1'b0;
      #1;
      check("vec_rsp_vld", bus.pe_rsp_vld, 1'b1);
      check("vec_rsp_data", bus.pe_rsp_data, v.exp_rsp);
      bus.pe_rsp_rdy = 1'b1;
      tick();
      bus.pe_rsp_rdy = 1'b0;
      #1;
    end
    check("vec_busy_done", bus.busy, 1'b0);
    check("vec_proto_err", bus.proto_err, 1'b0);
  endtask

  // Stream loads with an always-granting interconnect returning data after 2 cycles.
  task automatic run_loads(input int n, input int cycles, output int pushes, output int grants);
    logic [1:0]  gp;
    logic [31:0] rets;
    logic        g;
    gp = '0; rets = '0; pushes = 0; grants = 0;
    for (int c = 0; c < cycles; c++) begin
      bus.pe_req_vld       = (pushes < n);
      bus.pe_req_st        = 1'b0;
      bus.pe_req_bank_id   = 4'(c);
      bus.pe_req_bank_addr = 10'(pushes);
      bus.ld_data_vld      = gp[1];
      bus.ld_data          = 32'h100 + rets;
      #1;
      bus.gnt = bus.req_vld;
      g = bus.req_vld;
      if (bus.pe_req_vld && bus.pe_req_rdy) pushes++;
      if (g) grants++;
      if (gp[1]) rets = rets + 32'd1;
      tick();
      gp = {gp[0], g};
    end
    idle_inputs();
  endtask

  vec_t vecs [5];
  int   pushes, grants;
  logic stable;

  initial begin
    vecs[0] = '{1'b0, 4'd3,  10'h005, 32'h0,        32'h0000CAFE, 1'b0, 4'd3,  10'h005, 32'h0,        32'h0000CAFE};
    vecs[1] = '{1'b0, 4'd15, 10'h3FF, 32'h0,        32'hFFFFFFFF, 1'b0, 4'd15, 10'h3FF, 32'h0,        32'hFFFFFFFF};
    vecs[2] = '{1'b1, 4'd0,  10'h000, 32'h12345678, 32'h0,        1'b1, 4'd0,  10'h000, 32'h12345678, 32'h0};
    vecs[3] = '{1'b1, 4'd7,  10'h2AA, 32'hA5A5A5A5, 32'h0,        1'b1, 4'd7,  10'h2AA, 32'hA5A5A5A5, 32'h0};
    vecs[4] = '{1'b0, 4'd8,  10'h155, 32'h0,        32'h00000000, 1'b0, 4'd8,  10'h155, 32'h0,        32'h00000000};

    // Power-on reset
    rst = 1'b0;
    idle_inputs();
    #2;
    check("rst_req_rdy", bus.pe_req_rdy, 1'b0);
    check("rst_req_vld", bus.req_vld, 1'b0);
    check("rst_rsp_vld", bus.pe_rsp_vld, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_proto_err", bus.proto_err, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    check("post_rst_req_rdy", bus.pe_req_rdy, 1'b1);
    check("post_rst_busy", bus.busy, 1'b0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Credit stall: 6 loads, responses never consumed
    do_reset();
    run_loads(6, 20, pushes, grants);
    #1;
    check("stall_pushes", 64'(pushes), 64'd6);
    check("stall_grants", 64'(grants), 64'd4);
    check("stall_req_vld", bus.req_vld, 1'b0);
    check("stall_head_is_load", bus.req_st, 1'b0);
    check("stall_rsp_first", bus.pe_rsp_data, 32'h100);
    check("stall_proto_err", bus.proto_err, 1'b0);
    bus.pe_rsp_rdy = 1'b1;
    tick();
    bus.pe_rsp_rdy = 1'b0;
    #1;
    check("stall_release_req_vld", bus.req_vld, 1'b1);
    check("stall_rsp_second", bus.pe_rsp_data, 32'h101);

    // Store bypasses a full response FIFO and consumes no credit
    do_reset();
    run_loads(4, 12, pushes, grants);
    #1;
    check("byp_grants", 64'(grants), 64'd4);
    push_req(1'b1, 4'd9, 10'h077, 32'hDEADBEEF);
    #1;
    check("byp_req_vld", bus.req_vld, 1'b1);
    check("byp_req_st", bus.req_st, 1'b1);
    check("byp_st_data", bus.st_data, 32'hDEADBEEF);
    check("byp_bank", bus.mem_bank_id, 4'd9);
    check("byp_addr", bus.bank_addr, 10'h077);
    bus.gnt = 1'b1;
    tick();
    bus.gnt = 1'b0;
    push_req(1'b0, 4'd1, 10'h012, 32'h0);
    #1;
    check("byp_load_blocked", bus.req_vld, 1'b0);
    bus.pe_rsp_rdy = 1'b1;
    tick();
    bus.pe_rsp_rdy = 1'b0;
    #1;
    check("byp_inflight_unchanged", bus.req_vld, 1'b1);
    check("byp_proto_err", bus.proto_err, 1'b0);

    // Full request FIFO, head stability, no push during a pop from full
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      bus.pe_req_vld       = 1'b1;
      bus.pe_req_st        = 1'b1;
      bus.pe_req_bank_id   = 4'(i);
      bus.pe_req_bank_addr = 10'(i);
      bus.pe_req_wr_data   = 32'h1000 + 32'(i);
      tick();
    end
    bus.pe_req_bank_id   = 4'd14;
    bus.pe_req_bank_addr = 10'h03E;
    bus.pe_req_wr_data   = 32'h5555;
    #1;
    check("full_req_rdy", bus.pe_req_rdy, 1'b0);
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (bus.mem_bank_id !== 4'd1 || bus.bank_addr !== 10'd1 ||
          bus.st_data !== 32'h1001 || bus.req_vld !== 1'b1) stable = 1'b0;
      tick();
      #1;
    end
    check("full_head_stable", stable, 1'b1);
    bus.gnt = 1'b1;
    #1;
    check("full_pop_rdy", bus.pe_req_rdy, 1'b0);
    tick();
    bus.gnt = 1'b0;
    bus.pe_req_vld = 1'b0;
    #1;
    check("full_after_pop_rdy", bus.pe_req_rdy, 1'b1);
    for (int i = 2; i <= 4; i++) begin
      check("full_drain_addr", bus.bank_addr, 10'(i));
      bus.gnt = 1'b1;
      tick();
      bus.gnt = 1'b0;
      #1;
    end
    check("full_no_extra_push", bus.req_vld, 1'b0);
    check("full_busy", bus.busy, 1'b0);

    // Grant and return in the same cycle; response push and pop together
    do_reset();
    push_req(1'b0, 4'd1, 10'h00A, 32'h0);
    push_req(1'b0, 4'd2, 10'h00B, 32'h0);
    push_req(1'b0, 4'd3, 10'h00C, 32'h0);
    #1;
    check("sim_a_head", bus.bank_addr, 10'h00A);
    bus.gnt = 1'b1;
    tick();
    bus.gnt = 1'b0;
    tick();
    bus.gnt = 1'b1; bus.ld_data_vld = 1'b1; bus.ld_data = 32'h11;
    #1;
    check("sim_b_vld", bus.req_vld, 1'b1);
    check("sim_b_head", bus.bank_addr, 10'h00B);
    tick();
    bus.gnt = 1'b0; bus.ld_data_vld = 1'b0;
    tick();
    bus.gnt = 1'b1; bus.ld_data_vld = 1'b1; bus.ld_data = 32'h22;
    #1;
    check("sim_c_vld", bus.req_vld, 1'b1);
    check("sim_c_head", bus.bank_addr, 10'h00C);
    tick();
    bus.gnt = 1'b0; bus.ld_data_vld = 1'b0;
    tick();
    bus.ld_data_vld = 1'b1; bus.ld_data = 32'h33; bus.pe_rsp_rdy = 1'b1;
    #1;
    check("sim_rsp_a", bus.pe_rsp_data, 32'h11);
    tick();
    bus.ld_data_vld = 1'b0; bus.pe_rsp_rdy = 1'b0;
    #1;
    check("sim_rsp_b_vld", bus.pe_rsp_vld, 1'b1);
    check("sim_rsp_b", bus.pe_rsp_data, 32'h22);
    bus.pe_rsp_rdy = 1'b1;
    tick();
    #1;
    check("sim_rsp_c", bus.pe_rsp_data, 32'h33);
    tick();
    bus.pe_rsp_rdy = 1'b0;
    #1;
    check("sim_rsp_empty", bus.pe_rsp_vld, 1'b0);
    check("sim_busy", bus.busy, 1'b0);
    check("sim_proto_err", bus.proto_err, 1'b0);

    // Protocol errors and reset with queued work
    do_reset();
    bus.ld_data_vld = 1'b1; bus.ld_data = 32'h77;
    tick();
    bus.ld_data_vld = 1'b0;
    #1;
    check("err_spurious_ret", bus.proto_err, 1'b1);
    check("err_ret_dropped", bus.pe_rsp_vld, 1'b0);
    do_reset();
    #1;
    check("err_cleared", bus.proto_err, 1'b0);
    bus.gnt = 1'b1;
    tick();
    bus.gnt = 1'b0;
    #1;
    check("err_gnt_no_vld", bus.proto_err, 1'b1);
    for (int c = 0; c < 3; c++) tick();
    check("err_held", bus.proto_err, 1'b1);
    push_req(1'b1, 4'd1, 10'h001, 32'h1);
    push_req(1'b0, 4'd2, 10'h002, 32'h0);
    push_req(1'b1, 4'd3, 10'h003, 32'h3);
    #1;
    check("q3_busy", bus.busy, 1'b1);
    rst = 1'b0;
    #1;
    check("midrst_req_rdy", bus.pe_req_rdy, 1'b0);
    check("midrst_req_vld", bus.req_vld, 1'b0);
    check("midrst_rsp_vld", bus.pe_rsp_vld, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_proto_err", bus.proto_err, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    check("midrst_after_rdy", bus.pe_req_rdy, 1'b1);
    check("midrst_after_busy", bus.busy, 1'b0);
    check("midrst_after_req_vld", bus.req_vld, 1'b0);
    check("midrst_after_err", bus.proto_err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
